// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the 32-word data memory.
// Optional DMEM_ARB_RR_EN: round-robin arbitration; default is fixed priority with port 0 winning.
module dmem_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_read_q, mem_read_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;

    logic          any_req_c;
    logic          win1_c;

    assign any_req_c = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    // Most recently granted port; on a tie the other port wins.
    logic last_q;

    assign win1_c = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req_c) begin
            last_q <= win1_c;
        end
    end
`else
    assign win1_c = req1 & ~req0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values; strobes for ACCESS are set up while leaving IDLE
    always_comb begin
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata_d     = rdata_q;
        busy_d      = (state_d != IDLE);
        mem_addr_d  = 32'd0;
        mem_wdata_d = '0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        we_d        = we_q;
        owner_d     = owner_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    owner_d     = win1_c;
                    we_d        = win1_c ? we1 : we0;
                    gnt0_d      = ~win1_c;
                    gnt1_d      = win1_c;
                    mem_addr_d  = 32'(win1_c ? addr1 : addr0);
                    mem_wdata_d = win1_c ? wdata1 : wdata0;
                    mem_write_d = we_d;
                    mem_read_d  = ~we_d;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d   = mem_rdata;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                end
            end
            default: ;
        endcase
    end

    // Output and transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 32-word memory model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    // Memory model: write lands on the clock edge, read is combinational
    always @(posedge clk) if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[4:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes must never overlap, and grants are exclusive
    always @(negedge clk) begin
        if (mon_en) begin
            check("rw_excl", 32'(mem_write & mem_read), 32'd0);
            check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
        end
    end

    initial begin
        logic [1:0] exp_order [4];
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes", 32'({mem_write, mem_read}), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Simultaneous requests held for four grants
`ifdef DMEM_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        req0 = 1'b1; req1 = 1'b1; addr0 = 5'd2; addr1 = 5'd3;
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("tie_gnt%0d", g), 32'({gnt1, gnt0}), 32'(exp_order[g]));
            tick(); tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
        check("tie_idle", 32'(busy), 32'd0);

        // Port 0 write then read
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        check("w0_gnt", 32'({gnt1, gnt0}), 32'b01);
        check("w0_write", 32'({mem_write, mem_read}), 32'b10);
        check("w0_addr", mem_addr, 32'd5);
        check("w0_wdata", mem_wdata, 32'hDEADBEEF);
        check("w0_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        tick();
        check("w0_done_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("w0_done_strobes", 32'({mem_write, mem_read}), 32'd0);
        check("w0_done_addr", mem_addr, 32'd0);
        check("w0_done_wdata", mem_wdata, 32'd0);
        check("w0_done_rdata", rdata, 32'd0);
        tick();
        check("w0_idle", 32'(busy), 32'd0);
        req0 = 1'b1; we0 = 1'b0;
        tick();
        check("r0_gnt", 32'(gnt0), 32'd1);
        check("r0_read", 32'({mem_write, mem_read}), 32'b01);
        check("r0_addr", mem_addr, 32'd5);
        req0 = 1'b0;
        tick();
        check("r0_rvalid", 32'({rvalid1, rvalid0}), 32'b01);
        check("r0_rdata", rdata, 32'hDEADBEEF);
        tick();
        check("r0_rvalid_pulse", 32'({rvalid1, rvalid0}), 32'd0);

        // Port 1 write and read of the top word
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd31; wdata1 = 32'h1;
        tick();
        check("w1_gnt", 32'({gnt1, gnt0}), 32'b10);
        check("w1_addr", mem_addr, 32'h0000001F);
        check("w1_write", 32'(mem_write), 32'd1);
        req1 = 1'b0;
        tick(); tick();
        req1 = 1'b1; we1 = 1'b0;
        tick();
        check("r1_gnt", 32'({gnt1, gnt0}), 32'b10);
        check("r1_addr", mem_addr, 32'h0000001F);
        req1 = 1'b0;
        tick();
        check("r1_rvalid", 32'({rvalid1, rvalid0}), 32'b10);
        check("r1_rdata", rdata, 32'h1);
        tick();

        // Reset while a read is in ACCESS
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
        tick();
        check("rr_access", 32'(mem_read), 32'd1);
        req0 = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_read", 32'(mem_read), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_rdata", rdata, 32'd0);
        check("rr_rvalid_a", 32'({rvalid1, rvalid0}), 32'd0);
        tick();
        check("rr_rvalid_b", 32'({rvalid1, rvalid0}), 32'd0);
        tick();

        // Request raised while busy waits for IDLE
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'h12345678;
        tick();
        check("busy_gnt0", 32'({gnt1, gnt0}), 32'b01);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd3;
        check("busy_g1_n1", 32'(gnt1), 32'd0);
        tick();
        check("busy_g1_n2", 32'(gnt1), 32'd0);
        tick();
        check("busy_g1_n3", 32'({gnt1, gnt0}), 32'b10);
        req1 = 1'b0;
        tick();
        check("busy_rvalid1", 32'({rvalid1, rvalid0}), 32'b10);
        check("busy_rdata", rdata, 32'h12345678);
        tick(); tick();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
